// File: rtl/row_col_pkg.sv
// Shared helpers for the row/column matrix buffer.
// Row width, read-mode encoding and full-flag popcount.
package row_col_pkg;

    localparam logic RD_ROW = 1'b0;
    localparam logic RD_COL = 1'b1;

    function automatic int row_width(input int dw, input int n);
        return dw * n;
    endfunction

    // Up to four banks; callers zero-extend narrower flag vectors.
    function automatic logic [2:0] popcount(input logic [3:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/row_col_bank.sv
// One matrix bank: row write port and a combinational
// row or column (transposed) read mux.
module row_col_bank
    import row_col_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SIZE       = 16,
    parameter int ADDR_BITS  = 4,
    parameter int ROW_WIDTH  = row_width(DATA_WIDTH, SIZE)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] wr_row,
    input  logic [ROW_WIDTH-1:0] wr_data,
    input  logic [ADDR_BITS-1:0] rd_index,
    input  logic                 rd_col,
    output logic [ROW_WIDTH-1:0] rd_data
);

    logic [ROW_WIDTH-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        for (int r = 0; r < SIZE; r++) begin
            if (we && wr_row == ADDR_BITS'(r)) begin
                mem[r] <= wr_data;
            end
        end
    end

    // Out-of-range indices match nothing and read back as zero.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < SIZE; r++) begin
            if (rd_col == RD_COL) begin
                for (int j = 0; j < SIZE; j++) begin
                    if (rd_index == ADDR_BITS'(j)) begin
                        rd_data[r*DATA_WIDTH +: DATA_WIDTH] =
                            mem[r][j*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end else if (rd_index == ADDR_BITS'(r)) begin
                rd_data = mem[r];
            end
        end
    end

endmodule

// File: rtl/row_col_buffer.sv
// Multi-bank ring of matrix buffers: producer fills rows,
// consumer reads rows or columns of the oldest full matrix.
module row_col_buffer
    import row_col_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ROW_COL_SIZE = 16,
    parameter int MATRIX_SIZE  = 16,
    parameter int NUM_BANKS    = 2,
    parameter int ADDR_BITS    =
        ($clog2(MATRIX_SIZE) < 1) ? 1 : $clog2(MATRIX_SIZE),
    parameter int CNT_BITS     = $clog2(NUM_BANKS + 1)
) (
    input  logic                               clk,
    input  logic                               nreset,
    input  logic                               wr_valid,
    output logic                               wr_ready,
    input  logic [ROW_COL_SIZE*DATA_WIDTH-1:0] wr_data,
    input  logic                               wr_abort,
    input  logic                               rd_req_valid,
    output logic                               rd_req_ready,
    input  logic [ADDR_BITS-1:0]               rd_req_index,
    input  logic                               rd_req_col,
    output logic                               rd_resp_valid,
    input  logic                               rd_resp_ready,
    output logic [ROW_COL_SIZE*DATA_WIDTH-1:0] rd_resp_data,
    output logic                               rd_resp_err,
    input  logic                               rd_release,
    output logic                               matrix_avail,
    output logic [CNT_BITS-1:0]                full_count
);

    localparam int RW = row_width(DATA_WIDTH, ROW_COL_SIZE);
    localparam int PB = (NUM_BANKS > 2) ? 2 : 1;

    typedef logic [PB-1:0] ptr_t;

    if (ROW_COL_SIZE != MATRIX_SIZE) begin : g_size_chk
        $error("row_col_buffer: ROW_COL_SIZE != MATRIX_SIZE");
    end
    if (NUM_BANKS < 2 || NUM_BANKS > 4) begin : g_bank_chk
        $error("row_col_buffer: NUM_BANKS outside 2..4");
    end

    logic [NUM_BANKS-1:0] full;
    logic [NUM_BANKS-1:0] full_nxt;
    ptr_t                 fill_ptr;
    ptr_t                 drain_ptr;
    logic [ADDR_BITS-1:0] wr_row;
    logic [RW-1:0]        bank_rd [NUM_BANKS];
    logic [RW-1:0]        drain_rd;
    logic                 wr_acc;
    logic                 wr_last;
    logic                 rd_acc;
    logic                 rel;
    logic                 idx_err;

    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == ptr_t'(NUM_BANKS - 1)) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    assign wr_ready     = !full[fill_ptr];
    assign matrix_avail = full[drain_ptr];
    assign full_count   = CNT_BITS'(popcount(4'(full)));
    assign rd_req_ready = matrix_avail &&
                          (!rd_resp_valid || rd_resp_ready);

    assign wr_acc  = wr_valid && wr_ready && !wr_abort;
    assign wr_last = wr_row == ADDR_BITS'(MATRIX_SIZE - 1);
    assign rd_acc  = rd_req_valid && rd_req_ready;
    assign rel     = rd_release && matrix_avail;
    assign idx_err = {1'b0, rd_req_index} >=
                     (ADDR_BITS + 1)'(MATRIX_SIZE);

    assign drain_rd = bank_rd[drain_ptr];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        row_col_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .SIZE       (MATRIX_SIZE),
            .ADDR_BITS  (ADDR_BITS),
            .ROW_WIDTH  (RW)
        ) u_bank (
            .clk      (clk),
            .we       (wr_acc && fill_ptr == ptr_t'(b)),
            .wr_row   (wr_row),
            .wr_data  (wr_data),
            .rd_index (rd_req_index),
            .rd_col   (rd_req_col),
            .rd_data  (bank_rd[b])
        );
    end

    // Fill and drain never hit the same bank in one cycle:
    // a full fill bank blocks the write.
    always_comb begin
        full_nxt = full;
        if (wr_acc && wr_last) begin
            full_nxt[fill_ptr] = 1'b1;
        end
        if (rel) begin
            full_nxt[drain_ptr] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            full      <= '0;
            fill_ptr  <= '0;
            drain_ptr <= '0;
            wr_row    <= '0;
        end else begin
            full <= full_nxt;
            if (wr_abort) begin
                wr_row <= '0;
            end else if (wr_acc) begin
                if (wr_last) begin
                    wr_row   <= '0;
                    fill_ptr <= ptr_next(fill_ptr);
                end else begin
                    wr_row <= wr_row + 1'b1;
                end
            end
            if (rel) begin
                drain_ptr <= ptr_next(drain_ptr);
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_resp_valid <= 1'b0;
            rd_resp_data  <= '0;
            rd_resp_err   <= 1'b0;
        end else if (rd_acc) begin
            rd_resp_valid <= 1'b1;
            rd_resp_data  <= idx_err ? '0 : drain_rd;
            rd_resp_err   <= idx_err;
        end else if (rd_resp_ready) begin
            rd_resp_valid <= 1'b0;
        end
    end

endmodule
